// File: rtl/button_debouncer.sv
// button_debouncer
// Debounces one raw push-button level and turns each qualified press into
// clean enable pulses for the game core: SCEN once per press, MCEN once per
// press plus periodic auto-repeat while the button stays held. DPB is the
// debounced level. All outputs are decoded from the state register only, so
// an asynchronous reset forces them low without waiting for a clock edge.

module button_debouncer #(
    parameter int N_DC  = 20,
    parameter int N_RPT = 25
) (
    input  logic Clk,
    input  logic reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN
);

    // Terminal counts for the single shared counter. The debounce limit is
    // zero-extended into the wider repeat-counter width.
    localparam logic [N_RPT-1:0] DC_MAX  = N_RPT'((64'd1 << N_DC) - 64'd1);
    localparam logic [N_RPT-1:0] RPT_MAX = '1;
    localparam logic [N_RPT-1:0] CNT_ONE = N_RPT'(1);

    typedef enum logic [2:0] {
        INI     = 3'b000,
        WQ      = 3'b001,
        SCEN_ST = 3'b010,
        HELD    = 3'b011,
        MCEN_ST = 3'b100,
        WFCR    = 3'b101
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N_RPT-1:0] cnt;
    logic [N_RPT-1:0] cnt_next;
    logic             pb_s1;
    logic             pb_s2;

    // Two-flop synchronizer: PB is asynchronous to Clk, so only pb_s2 is
    // ever allowed to reach the state machine.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pb_s1 <= 1'b0;
            pb_s2 <= 1'b0;
        end else begin
            pb_s1 <= PB;
            pb_s2 <= pb_s1;
        end
    end

    // State and counter registers; reset drops straight back to idle.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= INI;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state/counter logic plus Moore output decode. Every counting
    // state tests its terminal count before incrementing, so cnt never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        DPB        = 1'b0;
        SCEN       = 1'b0;
        MCEN       = 1'b0;

        case (state)
            INI: begin
                if (pb_s2) begin
                    state_next = WQ;
                    cnt_next   = '0;
                end
            end

            WQ: begin
                if (!pb_s2) begin
                    state_next = INI;
                end else if (cnt == DC_MAX) begin
                    state_next = SCEN_ST;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            SCEN_ST: begin
                DPB        = 1'b1;
                SCEN       = 1'b1;
                MCEN       = 1'b1;
                state_next = HELD;
                cnt_next   = '0;
            end

            HELD: begin
                DPB = 1'b1;
                if (!pb_s2) begin
                    state_next = WFCR;
                    cnt_next   = '0;
                end else if (cnt == RPT_MAX) begin
                    state_next = MCEN_ST;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            MCEN_ST: begin
                DPB        = 1'b1;
                MCEN       = 1'b1;
                state_next = HELD;
                cnt_next   = '0;
            end

            WFCR: begin
                DPB = 1'b1;
                if (pb_s2) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == DC_MAX) begin
                    state_next = INI;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = INI;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
// Drives directed press scenarios and randomized button runs into a small
// debouncer instance and compares every cycle against a run-length model of
// the intended behaviour, plus directed pulse-count checks per scenario.

module tb_button_debouncer;

    localparam int N_DC  = 3;
    localparam int N_RPT = 5;

    // Run lengths of synchronized samples that trigger each event.
    localparam int PRESS_SAMPLES   = (1 << N_DC) + 1;
    localparam int REPEAT_SAMPLES  = (1 << N_RPT);
    localparam int RELEASE_SAMPLES = (1 << N_DC) + 1;

    logic Clk;
    logic reset;
    logic PB;
    logic DPB;
    logic SCEN;
    logic MCEN;

    int checks_total;
    int checks_passed;

    string stage;

    // Reference model state: a 2-deep delay line for the synchronizer and
    // run-length counters of consecutive synchronized samples.
    logic [1:0] m_q;
    logic       m_held;
    logic       m_skip;
    int         m_ones;
    int         m_zeros;
    int         m_rpt;
    logic       exp_dpb;
    logic       exp_scen;
    logic       exp_mcen;

    // Per-scenario observation counters.
    int cycle_idx;
    int scen_count;
    int mcen_count;
    int dpb_rises;
    int first_scen_idx;
    logic prev_dpb;

    button_debouncer #(
        .N_DC  (N_DC),
        .N_RPT (N_RPT)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .PB    (PB),
        .DPB   (DPB),
        .SCEN  (SCEN),
        .MCEN  (MCEN)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic model_reset();
        m_q      = 2'b00;
        m_held   = 1'b0;
        m_skip   = 1'b0;
        m_ones   = 0;
        m_zeros  = 0;
        m_rpt    = 0;
        exp_dpb  = 1'b0;
        exp_scen = 1'b0;
        exp_mcen = 1'b0;
    endtask

    task automatic model_edge(input logic pb_val);
        logic sample;
        sample   = m_q[1];
        m_q      = {m_q[0], pb_val};
        exp_scen = 1'b0;
        exp_mcen = 1'b0;
        if (!m_held) begin
            if (sample) m_ones++;
            else        m_ones = 0;
            if (m_ones == PRESS_SAMPLES) begin
                m_held   = 1'b1;
                m_skip   = 1'b1;
                m_zeros  = 0;
                m_rpt    = 0;
                exp_scen = 1'b1;
                exp_mcen = 1'b1;
            end
        end else if (m_skip) begin
            m_skip = 1'b0;
            m_rpt  = 0;
        end else if (sample) begin
            if (m_zeros != 0) begin
                m_zeros = 0;
                m_rpt   = 0;
            end else begin
                m_rpt++;
                if (m_rpt == REPEAT_SAMPLES) begin
                    exp_mcen = 1'b1;
                    m_skip   = 1'b1;
                end
            end
        end else begin
            m_zeros++;
            if (m_zeros == RELEASE_SAMPLES) begin
                m_held = 1'b0;
                m_ones = 0;
            end
        end
        exp_dpb = m_held;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks_total++;
        assert (obs === exp_v) checks_passed++;
        else $error("FAIL %s.%s observed=%b expected=%b", stage, tag, obs, exp_v);
    endtask

    task automatic check_count(input string tag, input int obs, input int exp_v);
        checks_total++;
        assert (obs === exp_v) checks_passed++;
        else $error("FAIL %s.%s observed=%0d expected=%0d", stage, tag, obs, exp_v);
    endtask

    task automatic checkOutput();
        check_bit("dpb",  DPB,  exp_dpb);
        check_bit("scen", SCEN, exp_scen);
        check_bit("mcen", MCEN, exp_mcen);
    endtask

    task automatic clear_phase(input string name);
        stage          = name;
        cycle_idx      = 0;
        scen_count     = 0;
        mcen_count     = 0;
        dpb_rises      = 0;
        first_scen_idx = -1;
        prev_dpb       = DPB;
        $display("[TB] scenario %s", name);
    endtask

    // One clock of stimulus: PB is set away from the rising edge, the model
    // advances on the edge, and outputs are compared on the falling edge.
    task automatic applyStimulus(input logic pb_val);
        PB = pb_val;
        @(posedge Clk);
        if (!reset) model_edge(pb_val);
        @(negedge Clk);
        checkOutput();
        if (SCEN === 1'b1) begin
            scen_count++;
            if (first_scen_idx < 0) first_scen_idx = cycle_idx;
        end
        if (MCEN === 1'b1) mcen_count++;
        if (DPB === 1'b1 && prev_dpb !== 1'b1) dpb_rises++;
        prev_dpb = DPB;
        cycle_idx++;
    endtask

    task automatic run_level(input logic pb_val, input int n);
        for (int i = 0; i < n; i++) applyStimulus(pb_val);
    endtask

    // Directed scenarios followed by randomized button runs.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        stage         = "init";

        // Reset held with the button pressed: outputs must stay low.
        reset = 1'b1;
        PB    = 1'b1;
        model_reset();
        #1;
        stage = "reset_hold";
        checkOutput();
        run_level(1'b1, 3);
        reset = 1'b0;
        clear_phase("reset_release");
        run_level(1'b1, 15);
        check_count("scen_count", scen_count, 1);
        check_count("scen_index", first_scen_idx, 10);
        check_count("dpb_rises", dpb_rises, 1);
        run_level(1'b0, 15);

        // Bouncing input never stays stable long enough to qualify.
        clear_phase("bounce");
        for (int i = 0; i < 40; i++) applyStimulus(((i / 3) % 2) == 0);
        run_level(1'b0, 10);
        check_count("scen_count", scen_count, 0);
        check_count("mcen_count", mcen_count, 0);
        check_count("dpb_rises", dpb_rises, 0);

        // Short clean press: one pulse, no repeat.
        clear_phase("clean_press");
        run_level(1'b1, 20);
        run_level(1'b0, 15);
        check_count("scen_count", scen_count, 1);
        check_count("mcen_count", mcen_count, 1);

        // Long hold: press pulse plus three repeats.
        clear_phase("auto_repeat");
        run_level(1'b1, 120);
        run_level(1'b0, 15);
        check_count("scen_count", scen_count, 1);
        check_count("mcen_count", mcen_count, 4);

        // Release bounce must not produce a second press or drop DPB early.
        clear_phase("release_bounce");
        run_level(1'b1, 12);
        run_level(1'b0, 2);
        run_level(1'b1, 10);
        run_level(1'b0, 15);
        check_count("scen_count", scen_count, 1);
        check_count("dpb_rises", dpb_rises, 1);

        // Reset while held: outputs drop immediately, press re-qualifies.
        clear_phase("reset_mid_hold");
        run_level(1'b1, 20);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput();
        applyStimulus(1'b1);
        reset = 1'b0;
        clear_phase("post_reset_press");
        run_level(1'b1, 15);
        check_count("scen_count", scen_count, 1);
        check_count("scen_index", first_scen_idx, 10);
        run_level(1'b0, 15);

        // Random runs of held/released levels of varying length.
        clear_phase("random");
        begin
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            for (int r = 0; r < 30; r++) begin
                run_level(lvl, int'($urandom_range(1, 45)));
                lvl = ~lvl;
            end
        end
        run_level(1'b0, 20);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
